// File: rtl/v_ch_arbiter.sv
// Round-robin arbiter sharing one AHB master between N_CH DMA channels; grant held until burst ends.
// Optional V_CH_ARB_PRIO_EN adds a 2-bit per-channel priority with round-robin tie-break.
module v_ch_arbiter #(
    parameter int unsigned N_CH = 4,
    localparam int unsigned IDX_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [N_CH-1:0]   ch_rd_req_i,
    input  logic [N_CH-1:0]   ch_wr_req_i,
    input  logic [N_CH-1:0]   ch_mask_i,
`ifdef V_CH_ARB_PRIO_EN
    input  logic [2*N_CH-1:0] ch_prio_i,
`endif
    input  logic              m_done_i,
    input  logic              m_err_i,
    output logic              m_start_o,
    output logic              m_mode_o,
    output logic [N_CH-1:0]   grant_o,
    output logic [IDX_W-1:0]  grant_idx_o,
    output logic              grant_valid_o,
    output logic              err_pulse_o,
    output logic [IDX_W-1:0]  err_idx_o
);

    typedef enum logic [1:0] {StIdle, StStart, StBusy, StRelease} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              mode_q, mode_d;
    logic              err_pulse_q, err_pulse_d;
    logic [IDX_W-1:0]  err_idx_q, err_idx_d;

    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   cand;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    int                j;
`ifdef V_CH_ARB_PRIO_EN
    logic [1:0]        best;
`endif

    // Winner search: circular scan from ptr+1 over the candidate set.
    always_comb begin
        req       = (ch_rd_req_i | ch_wr_req_i) & ch_mask_i;
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        j         = 0;
`ifdef V_CH_ARB_PRIO_EN
        best = 2'd0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (req[k] && (ch_prio_i[2*k +: 2] > best)) begin
                best = ch_prio_i[2*k +: 2];
            end
        end
        for (int k = 0; k < int'(N_CH); k++) begin
            cand[k] = req[k] && (ch_prio_i[2*k +: 2] == best);
        end
`else
        cand = req;
`endif
        for (int i = 1; i <= int'(N_CH); i++) begin
            j = int'(ptr_q) + i;
            if (j >= int'(N_CH)) begin
                j = j - int'(N_CH);
            end
            if (!win_found && cand[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        err_pulse_d = 1'b0;
        err_idx_d   = err_idx_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    idx_d   = win_idx;
                    // Read wins when a channel raises both levels.
                    mode_d  = ~ch_rd_req_i[win_idx];
                    state_d = StStart;
                end
            end
            StStart: state_d = StBusy;
            StBusy: begin
                if (m_err_i) begin
                    err_pulse_d = 1'b1;
                    err_idx_d   = idx_q;
                    state_d     = StRelease;
                end else if (m_done_i) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                ptr_d   = idx_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q     <= StIdle;
            ptr_q       <= IDX_W'(N_CH - 1);
            idx_q       <= '0;
            mode_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            err_pulse_q <= err_pulse_d;
            err_idx_q   <= err_idx_d;
        end
    end

    always_comb begin
        grant_valid_o = (state_q == StStart) || (state_q == StBusy);
        m_start_o     = (state_q == StStart);
        m_mode_o      = grant_valid_o & mode_q;
        grant_idx_o   = grant_valid_o ? idx_q : '0;
        grant_o       = '0;
        if (grant_valid_o) begin
            grant_o[idx_q] = 1'b1;
        end
        err_pulse_o   = err_pulse_q;
        err_idx_o     = err_idx_q;
    end

endmodule

// File: tb/tb_v_ch_arbiter.sv
// Self-checking bench for v_ch_arbiter: expected grants queued at stimulus, checked on each start pulse.
module tb_v_ch_arbiter;

    localparam int unsigned N_CH = 4;
    localparam int unsigned IDX_W = 2;

    logic              clk;
    logic              areset;
    logic [N_CH-1:0]   ch_rd_req_i;
    logic [N_CH-1:0]   ch_wr_req_i;
    logic [N_CH-1:0]   ch_mask_i;
`ifdef V_CH_ARB_PRIO_EN
    logic [2*N_CH-1:0] ch_prio_i;
`endif
    logic              m_done_i;
    logic              m_err_i;
    logic              m_start_o;
    logic              m_mode_o;
    logic [N_CH-1:0]   grant_o;
    logic [IDX_W-1:0]  grant_idx_o;
    logic              grant_valid_o;
    logic              err_pulse_o;
    logic [IDX_W-1:0]  err_idx_o;

    int errors = 0;
    int checks = 0;
    int exp_q[$];  // each entry: idx*2 + mode

    v_ch_arbiter #(.N_CH(N_CH)) dut (
        .clk          (clk),
        .areset       (areset),
        .ch_rd_req_i  (ch_rd_req_i),
        .ch_wr_req_i  (ch_wr_req_i),
        .ch_mask_i    (ch_mask_i),
`ifdef V_CH_ARB_PRIO_EN
        .ch_prio_i    (ch_prio_i),
`endif
        .m_done_i     (m_done_i),
        .m_err_i      (m_err_i),
        .m_start_o    (m_start_o),
        .m_mode_o     (m_mode_o),
        .grant_o      (grant_o),
        .grant_idx_o  (grant_idx_o),
        .grant_valid_o(grant_valid_o),
        .err_pulse_o  (err_pulse_o),
        .err_idx_o    (err_idx_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every start pulse must match the next queued grant.
    always @(negedge clk) begin
        if (areset === 1'b1 && m_start_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: start for ch %0d, no grant expected", grant_idx_o);
            end else begin
                int e;
                logic [N_CH-1:0] eg;
                e = exp_q.pop_front();
                eg = '0;
                eg[e / 2] = 1'b1;
                if (grant_idx_o !== IDX_W'(e / 2) || m_mode_o !== e[0] || grant_o !== eg
                    || grant_valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL sb_grant: idx=%0d mode=%b grant=%b valid=%b, need idx=%0d mode=%b grant=%b valid=1",
                             grant_idx_o, m_mode_o, grant_o, grant_valid_o, e / 2, e[0], eg);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset      = 1'b0;
        ch_rd_req_i = '0;
        ch_wr_req_i = '0;
        ch_mask_i   = '1;
        m_done_i    = 1'b0;
        m_err_i     = 1'b0;
`ifdef V_CH_ARB_PRIO_EN
        ch_prio_i   = '0;
`endif
        tick();
        tick();
        areset = 1'b1;
    endtask

    task automatic wait_start();
        int n = 0;
        while (m_start_o !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (m_start_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_start: m_start_o=%b, need 1 within 30 cycles", m_start_o);
        end
    endtask

    // Waits for a start, lets the master run `lat` cycles, then pulses done for one cycle.
    task automatic run_burst(input int lat);
        wait_start();
        repeat (lat) tick();
        m_done_i = 1'b1;
        tick();
        m_done_i = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b0;
        ch_rd_req_i = '0; ch_wr_req_i = '0; ch_mask_i = '0;
        m_done_i = 1'b0; m_err_i = 1'b0;
`ifdef V_CH_ARB_PRIO_EN
        ch_prio_i = '0;
`endif
        #3;
        checks++;
        if ({m_start_o, m_mode_o, grant_o, grant_idx_o, grant_valid_o, err_pulse_o, err_idx_o} !== '0)
        begin
            errors++;
            $display("FAIL reset_outputs: start=%b mode=%b grant=%b idx=%0d valid=%b errp=%b erridx=%0d, need all 0",
                     m_start_o, m_mode_o, grant_o, grant_idx_o, grant_valid_o, err_pulse_o, err_idx_o);
        end
        tick();
        areset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        exp_q.push_back(0 * 2 + 0);
        ch_rd_req_i = 4'b0001;
        tick();
        checks++;
        if (grant_o !== 4'b0001 || m_start_o !== 1'b1 || grant_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%b start=%b valid=%b, need 0001 1 1",
                     grant_o, m_start_o, grant_valid_o);
        end
        tick();
        checks++;
        if (m_start_o !== 1'b0 || grant_o !== 4'b0001) begin
            errors++;
            $display("FAIL single_busy: start=%b grant=%b, need 0 0001", m_start_o, grant_o);
        end
        m_done_i = 1'b1;
        tick();
        m_done_i = 1'b0;
        ch_rd_req_i = '0;
        checks++;
        if (grant_valid_o !== 1'b0 || grant_o !== 4'b0000) begin
            errors++;
            $display("FAIL single_release: valid=%b grant=%b, need 0 0000", grant_valid_o, grant_o);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back((i % 4) * 2 + 1);
        ch_wr_req_i = 4'b1111;
        for (int i = 0; i < 5; i++) run_burst(5);
        ch_wr_req_i = '0;
        tick();
        tick();
    endtask

    task automatic test_mask_mode();
        do_reset();
        exp_q.push_back(1 * 2 + 1);
        exp_q.push_back(1 * 2 + 1);
        ch_rd_req_i = 4'b0100;
        ch_wr_req_i = 4'b0110;
        ch_mask_i   = 4'b1011;
        run_burst(2);
        run_burst(2);
        // Unmasked, channel 2 raises both levels: read must win.
        exp_q.push_back(2 * 2 + 0);
        ch_mask_i = 4'b1111;
        run_burst(2);
        ch_rd_req_i = '0;
        ch_wr_req_i = '0;
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mask_pending: %0d grants outstanding, need 0", exp_q.size());
        end
    endtask

    task automatic test_error();
        do_reset();
        exp_q.push_back(3 * 2 + 1);
        ch_wr_req_i = 4'b1000;
        wait_start();
        tick();
        m_err_i  = 1'b1;
        m_done_i = 1'b1;
        tick();
        m_err_i  = 1'b0;
        m_done_i = 1'b0;
        ch_wr_req_i = '0;
        checks++;
        if (err_pulse_o !== 1'b1 || err_idx_o !== 2'd3 || grant_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: errp=%b erridx=%0d valid=%b, need 1 3 0",
                     err_pulse_o, err_idx_o, grant_valid_o);
        end
        tick();
        checks++;
        if (err_pulse_o !== 1'b0 || err_idx_o !== 2'd3) begin
            errors++;
            $display("FAIL err_hold: errp=%b erridx=%0d, need 0 3", err_pulse_o, err_idx_o);
        end
        exp_q.push_back(0 * 2 + 0);
        ch_rd_req_i = 4'b1111;
        run_burst(1);
        ch_rd_req_i = '0;
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        exp_q.push_back(2 * 2 + 0);
        ch_rd_req_i = 4'b0100;
        wait_start();
        tick();
        #2;
        areset = 1'b0;
        #1;
        checks++;
        if ({m_start_o, m_mode_o, grant_o, grant_idx_o, grant_valid_o, err_pulse_o} !== '0) begin
            errors++;
            $display("FAIL midreset_async: grant=%b idx=%0d valid=%b start=%b, need all 0",
                     grant_o, grant_idx_o, grant_valid_o, m_start_o);
        end
        tick();
        areset = 1'b1;
        exp_q.push_back(0 * 2 + 0);
        ch_rd_req_i = 4'b1111;
        run_burst(1);
        ch_rd_req_i = '0;
        tick();
        tick();
    endtask

`ifdef V_CH_ARB_PRIO_EN
    task automatic test_prio();
        do_reset();
        // ch0=1, ch1=1, ch2=3, ch3=0
        ch_prio_i   = {2'd0, 2'd3, 2'd1, 2'd1};
        ch_rd_req_i = 4'b1111;
        for (int i = 0; i < 3; i++) exp_q.push_back(2 * 2 + 0);
        for (int i = 0; i < 3; i++) run_burst(1);
        ch_rd_req_i = 4'b1011;
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0);
        for (int i = 0; i < 3; i++) run_burst(1);
        ch_rd_req_i = 4'b1000;
        exp_q.push_back(3 * 2 + 0);
        run_burst(1);
        ch_rd_req_i = '0;
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask_mode();
        test_error();
        test_mid_reset();
`ifdef V_CH_ARB_PRIO_EN
        test_prio();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected grants never seen, need 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/v_ch_arbiter.md
Name: v_ch_arbiter

Overview:
- Round-robin scheduler that shares the single AHB master datapath between N_CH DMA channel controllers.
- Each channel asks for a read or write burst through its rush_read/rush_write levels. The arbiter picks one channel and drives the master's start strobe and mode.
- The grant is held until the master reports that the burst has ended or has failed. Sits between the channel array and the AHB master/mux.

Parameters:
- N_CH, 4, number of channels; legal range 2..16.
- IDX_W, $clog2(N_CH), width of the channel index (derived; not overridable).

Ports:
- clk  in  1  clock
- areset  in  1  asynchronous active-low reset
- ch_rd_req_i  in  N_CH  per-channel read-burst request (channel rush_read level)
- ch_wr_req_i  in  N_CH  per-channel write-burst request (channel rush_write level)
- ch_mask_i  in  N_CH  per-channel enable; a 0 bit hides that channel's requests
- m_done_i  in  1  master burst complete (last beat of read or write accepted)
- m_err_i  in  1  master error response during the granted burst
- m_start_o  out  1  one-cycle pulse that starts a burst on the master
- m_mode_o  out  1  0 = read burst, 1 = write burst; valid while grant_valid_o = 1
- grant_o  out  N_CH  one-hot grant; steers the address/data mux and i_next/i_last routing
- grant_idx_o  out  IDX_W  binary index of the granted channel
- grant_valid_o  out  1  a grant is active
- err_pulse_o  out  1  one-cycle pulse, burst of grant_idx_o ended with an error
- err_idx_o  out  IDX_W  channel index captured with err_pulse_o; held until the next error

Behaviour:
- Reset (areset = 0, asynchronous, any state):
  - state = IDLE; all outputs 0; RR pointer = N_CH-1, so channel 0 wins first.
  - Reset mid-burst drops the grant immediately; the master is reset by the same signal.
- Effective request per channel: req[k] = (ch_rd_req_i[k] | ch_wr_req_i[k]) & ch_mask_i[k].
- Winner: first k with req[k] = 1, scanning circularly from ptr+1 and wrapping past N_CH-1 to 0.
- Mode: if ch_rd_req_i[k] and ch_wr_req_i[k] are both set, read takes precedence (m_mode_o = 0).
- State IDLE:
  - Outputs deasserted.
  - If any req = 1, register winner, grant_o, grant_idx_o and m_mode_o, and set grant_valid_o = 1. Go to START. Arbitration latency is 1 cycle from request to grant.
- State START:
  - m_start_o = 1 for exactly this cycle. Go to BUSY.
  - m_done_i/m_err_i are ignored here; the master cannot finish in the same cycle.
- State BUSY:
  - Grant, index and mode are frozen. Changes on ch_*_req_i and ch_mask_i of any channel, including the granted one, are ignored until the burst ends.
  - m_err_i = 1 (priority over m_done_i if both are set): err_pulse_o = 1 next cycle, err_idx_o = grant_idx_o. Go to RELEASE.
  - m_done_i = 1 alone: go to RELEASE.
- State RELEASE:
  - grant_valid_o = 0, grant_o = 0; ptr <= granted index. Go to IDLE.
  - This bubble cycle lets the channel FSM leave READ/WRITE, so a finished channel is never re-granted on a stale request.
- Fairness: a continuously requesting channel waits at most N_CH-1 bursts.
- Back-to-back: IDLE→START→BUSY→RELEASE; the minimum period per burst is 3 cycles plus master time.
- Only one grant is ever active. grant_o is always one-hot or zero and always matches grant_idx_o.

Optional Feature:
- Macro: V_CH_ARB_PRIO_EN.
- When defined:
  - Adds input ch_prio_i (2*N_CH bits; 2-bit priority per channel, 3 = highest).
  - The winner is the highest-priority requesting channel. RR order from ptr+1 breaks ties within that level.
  - Still non-preemptive: a higher-priority request that arrives during BUSY waits for RELEASE.
- When undefined: the port is absent and arbitration is pure round-robin as above.

Test Plan:
- Single request: reset, then ch_rd_req_i = 0001. Required:
  - grant_o = 0001 one cycle later; m_start_o pulses in the next cycle; m_mode_o = 0.
  - After m_done_i, grant_valid_o falls within 1 cycle.
- Round-robin: all four channels request writes continuously; m_done_i pulses 5 cycles after each start. Required:
  - Grant order 0,1,2,3,0; m_mode_o = 1 throughout; no cycle with two grant bits set.
- Mask and mode: ch_rd_req_i = 0100, ch_wr_req_i = 0110, ch_mask_i = 1011. Required:
  - Channel 1 granted with m_mode_o = 1; channel 2 never granted while masked.
- Error: grant channel 3, then assert m_err_i and m_done_i in the same cycle. Required:
  - err_pulse_o = 1 for one cycle, err_idx_o = 3, grant released; next winner is channel 0 (pointer wrapped).
- Mid-burst reset: with channel 2 in BUSY, drop areset for 1 cycle. Required:
  - All outputs become 0 asynchronously; after release, channel 0 wins first.
- V_CH_ARB_PRIO_EN: priorities {3,1,1,0} for channels {2,0,1,3}, all requesting. Required:
  - Order 2,2,2,… while channel 2 keeps requesting; after it drops, 0 and 1 alternate; 3 is granted only when 0, 1 and 2 are idle.
